// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection. A hazard inserts one
// bubble and holds PC and IF/ID for a cycle; a flush squashes the ID instruction.
module id_ex_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_IF_ID,
  input  logic [2:0]        sourceAddress1_IF_ID,
  input  logic [2:0]        sourceAddress2_IF_ID,
  input  logic [2:0]        writeAddress_IF_ID,
  input  logic              regWrite_IF_ID,
  input  logic              memRead_IF_ID,
  input  logic [2:0]        aluOp_IF_ID,
  input  logic [DATA_W-1:0] readData1_IF_ID,
  input  logic [DATA_W-1:0] readData2_IF_ID,
  input  logic              flush,
  output logic              valid_ID_EX,
  output logic              regWrite_ID_EX,
  output logic              memRead_ID_EX,
  output logic [2:0]        sourceAddress1_ID_EX,
  output logic [2:0]        sourceAddress2_ID_EX,
  output logic [2:0]        writeAddress_ID_EX,
  output logic [2:0]        aluOp_ID_EX,
  output logic [DATA_W-1:0] readData1_ID_EX,
  output logic [DATA_W-1:0] readData2_ID_EX,
  output logic              stall,
  output logic [CNT_W-1:0]  stallCount
);

  typedef enum logic [0:0] {StRun, StBubble} state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic                reg_write_q, reg_write_d;
  logic                mem_read_q, mem_read_d;
  logic [2:0]          src1_q, src1_d;
  logic [2:0]          src2_q, src2_d;
  logic [2:0]          wr_addr_q, wr_addr_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   data1_q, data1_d;
  logic [DATA_W-1:0]   data2_q, data2_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                hazard;

  // Register 0 is hardwired zero, so a load targeting it never blocks a reader.
  assign hazard = valid_IF_ID & valid_q & mem_read_q & reg_write_q & (wr_addr_q != 3'd0) &
                  ((sourceAddress1_IF_ID == wr_addr_q) | (sourceAddress2_IF_ID == wr_addr_q));

  assign stall = hazard & (state_q == StRun) & ~flush;

  always_comb begin
    state_d     = StRun;
    valid_d     = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    src1_d      = 3'd0;
    src2_d      = 3'd0;
    wr_addr_d   = 3'd0;
    alu_op_d    = 3'd0;
    data1_d     = '0;
    data2_d     = '0;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      state_d = StRun;
    end else if (stall) begin
      state_d = StBubble;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else begin
      state_d     = StRun;
      valid_d     = valid_IF_ID;
      // An invalid instruction travels on, but must never write or load.
      reg_write_d = regWrite_IF_ID & valid_IF_ID;
      mem_read_d  = memRead_IF_ID & valid_IF_ID;
      src1_d      = sourceAddress1_IF_ID;
      src2_d      = sourceAddress2_IF_ID;
      wr_addr_d   = writeAddress_IF_ID;
      alu_op_d    = aluOp_IF_ID;
      data1_d     = readData1_IF_ID;
      data2_d     = readData2_IF_ID;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      src1_q      <= 3'd0;
      src2_q      <= 3'd0;
      wr_addr_q   <= 3'd0;
      alu_op_q    <= 3'd0;
      data1_q     <= '0;
      data2_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      wr_addr_q   <= wr_addr_d;
      alu_op_q    <= alu_op_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign valid_ID_EX          = valid_q;
  assign regWrite_ID_EX       = reg_write_q;
  assign memRead_ID_EX        = mem_read_q;
  assign sourceAddress1_ID_EX = src1_q;
  assign sourceAddress2_ID_EX = src2_q;
  assign writeAddress_ID_EX   = wr_addr_q;
  assign aluOp_ID_EX          = alu_op_q;
  assign readData1_ID_EX      = data1_q;
  assign readData2_ID_EX      = data2_q;
  assign stallCount           = stall_cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode (ID) and execute (EX) with built-in load-use hazard detection. It captures decoded operands, 3-bit register addresses and control bits each cycle. It supplies `sourceAddress*_ID_EX` to the forwarding logic that compares them against the EX/WB write port. When an instruction in EX is a load whose destination is read by the instruction in ID, the block inserts one bubble and stalls PC and IF/ID. A pipeline flush overrides everything.

## Interface
Parameters:
- `DATA_W`, default 8: operand width.
- `CNT_W`, default 8: stall counter width.

Ports:
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `valid_IF_ID`, in, 1: ID holds a real instruction.
- `sourceAddress1_IF_ID` / `sourceAddress2_IF_ID`, in, 3 each: rs1 / rs2 of the ID instruction.
- `writeAddress_IF_ID`, in, 3: rd of the ID instruction.
- `regWrite_IF_ID` / `memRead_IF_ID`, in, 1 each: ID control bits.
- `aluOp_IF_ID`, in, 3: ALU operation code.
- `readData1_IF_ID` / `readData2_IF_ID`, in, DATA_W each: register-file read data.
- `flush`, in, 1: squash the ID instruction (taken branch or jump).
- `valid_ID_EX`, `regWrite_ID_EX`, `memRead_ID_EX`, out, 1 each: registered copies of the ID inputs.
- `sourceAddress1_ID_EX`, `sourceAddress2_ID_EX`, `writeAddress_ID_EX`, `aluOp_ID_EX`, out, 3 each: registered copies.
- `readData1_ID_EX`, `readData2_ID_EX`, out, DATA_W each: registered copies.
- `stall`, out, 1: combinational; when 1, PC and IF/ID hold their values this cycle.
- `stallCount`, out, CNT_W: saturating count of stall cycles.

## Operation
- FSM has two states, RUN and BUBBLE. Reset state is RUN.
- `hazard` = `valid_IF_ID & valid_ID_EX & memRead_ID_EX & regWrite_ID_EX & (writeAddress_ID_EX != 0) & ((sourceAddress1_IF_ID == writeAddress_ID_EX) | (sourceAddress2_IF_ID == writeAddress_ID_EX))`.
- Address 0 is hardwired zero and never causes a hazard.
- `stall = hazard & (state == RUN) & ~flush`.
- Each rising edge, exactly one rule applies, in this priority order:
  1. `flush`=1: load a bubble and go to RUN.
  2. `stall`=1: load a bubble and go to BUBBLE.
  3. Otherwise: capture all `_IF_ID` inputs into the `_ID_EX` outputs and go to RUN.
- A bubble means all `_ID_EX` outputs are 0, which includes valid, control bits, addresses and data.
- In BUBBLE, `stall` is forced to 0, so the held instruction is always captured on the next edge. The load has then moved to EX/WB, and the forwarding unit resolves the dependency.
- An invalid ID instruction (`valid_IF_ID`=0) is still captured. All of its control bits are then gated to 0 in ID/EX.
- `stallCount` increments by 1 on each edge where `stall`=1. It saturates at 2^CNT_W-1 and never wraps.
- On reset, all outputs are 0 (`stall` is 0 because `valid_ID_EX`=0), `stallCount` is 0 and the state is RUN. Reset asserted mid-stall returns the block to RUN with an empty ID/EX.

## Timing
- Latency ID to EX is 1 cycle.
- `stall` is combinational from the current `_IF_ID` inputs and the registered `_ID_EX` state, and is valid in the same cycle.
- A load-use pair costs exactly 1 bubble cycle; back-to-back load-use pairs cost 1 bubble each.
- A `flush` in the same cycle as a hazard produces no stall and no count increment.
- Asynchronous reset takes effect immediately, with no dependence on `clk`.

## Test plan
- Reset, then one edge with no inputs active: all outputs are 0, state is RUN and `stallCount`=0.
- Pass-through: ID presents rd=3, rs1=1, rs2=2, `regWrite`=1, `readData1`=8'h5A. After one edge, the `_ID_EX` outputs equal these values and `stall` stays 0.
- Load-use: ID/EX holds a load with rd=4. ID presents an instruction with rs2=4, so `stall`=1 in that cycle. The next edge loads a bubble (`valid_ID_EX`=0) and the FSM enters BUBBLE. The following edge captures the instruction with rs2=4, and `stallCount`=1.
- No hazard on rd=0: ID/EX holds a load with rd=0 and ID reads rs1=0, so `stall`=0. Also a non-load in EX with a matching rd gives `stall`=0.
- Flush priority: a hazard condition is present together with `flush`=1. `stall`=0, the next edge loads a bubble, the state is RUN and `stallCount` is unchanged.
- Saturation: with CNT_W=2, run five load-use pairs; `stallCount` reaches 3 and holds at 3.
